// File: rtl/audio_i2s_tx_pkg.sv
// Shared audio definitions for the WM8731 serial transmitter.
//   FRAME_CLKS     : system clocks per 48 kHz frame (18.432 MHz / 48 kHz)
//   BCK_HALF       : system clocks per BCLK half-period
//   BITS_PER_FRAME : BCLK periods per frame (32 per channel slot)
//   atten_sample() : mute / power-of-two attenuation of one 16-bit sample
package audio_i2s_tx_pkg;

  localparam int FRAME_CLKS     = 384;
  localparam int BCK_HALF       = 3;
  localparam int BITS_PER_FRAME = 64;

  // Arithmetic right shift keeps the sign, so -1 stays -1 at any shift.
  // The shift is done on a signed temporary so that no unsigned operand
  // can turn it into a logical shift.
  function automatic logic [15:0] atten_sample(input logic [15:0] s,
                                               input logic [3:0]  sh,
                                               input logic        mute);
    logic signed [15:0] ss;
    logic signed [15:0] res;
    ss  = $signed(s);
    res = ss >>> sh;
    if (mute) begin
      return 16'h0000;
    end
    return res;
  endfunction

endpackage

// File: rtl/audio_clkgen.sv
// Frame timing generator for the I2S / left-justified transmitter.
// Ports:
//   clk, rst_n : system clock, synchronous active-low reset
//   bck        : registered bit clock (low for the first BCK_HALF clocks of a bit)
//   lrck       : registered frame clock, left level during bits 0..31
//   rd_stb     : registered one-cycle sample request, high while cnt = FRAME_CLKS-4
//   cap_stb    : high while cnt = FRAME_CLKS-2 (capture the requested sample)
//   load_stb   : high while cnt = FRAME_CLKS-1 (load the next frame)
//   shift_stb  : high on the last clock of every bit (next edge starts a new bit)
module audio_clkgen #(
  parameter int I2S_MODE   = 1,
  parameter int FRAME_CLKS = 384,
  parameter int BCK_HALF   = 3
) (
  input  logic clk,
  input  logic rst_n,
  output logic bck,
  output logic lrck,
  output logic rd_stb,
  output logic cap_stb,
  output logic load_stb,
  output logic shift_stb
);

  localparam int CW = $clog2(FRAME_CLKS);
  localparam int PW = $clog2(2 * BCK_HALF);

  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_CLKS - 1);
  localparam logic [CW-1:0] CNT_CAP  = CW'(FRAME_CLKS - 2);
  localparam logic [CW-1:0] CNT_RD   = CW'(FRAME_CLKS - 4);
  localparam logic [CW-1:0] CNT_HALF = CW'(FRAME_CLKS / 2);
  localparam logic [PW-1:0] PH_LAST  = PW'(2 * BCK_HALF - 1);
  localparam logic [PW-1:0] PH_HIGH  = PW'(BCK_HALF);

  // I2S frames the left channel with LRCK low, left-justified with LRCK high.
  localparam logic LEFT_LVL = (I2S_MODE != 0) ? 1'b0 : 1'b1;

  // ph runs alongside cnt instead of deriving cnt % (2*BCK_HALF); both
  // wrap together because FRAME_CLKS is a whole number of bit periods.
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [PW-1:0] ph;
  logic [PW-1:0] ph_next;

  always_comb begin
    cnt_next = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    ph_next  = (ph == PH_LAST) ? '0 : ph + 1'b1;
  end

  // Registered outputs are computed from the next count so that they line
  // up with the cycle in which cnt holds that value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      ph     <= '0;
      bck    <= 1'b0;
      lrck   <= LEFT_LVL;
      rd_stb <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      ph     <= ph_next;
      bck    <= (ph_next >= PH_HIGH);
      lrck   <= (cnt_next < CNT_HALF) ? LEFT_LVL : ~LEFT_LVL;
      rd_stb <= (cnt_next == CNT_RD);
    end
  end

  assign cap_stb   = (cnt == CNT_CAP);
  assign load_stb  = (cnt == CNT_LAST);
  assign shift_stb = (ph == PH_LAST);

endmodule

// File: rtl/audio_i2s_tx.sv
// Serial audio transmitter for the WM8731 DAC (BCLK/LRCK master).
// Requests one stereo sample per frame, applies mute / attenuation and
// shifts it out as I2S (I2S_MODE = 1) or left-justified (I2S_MODE = 0).
// Ports:
//   iCLK_18_4 : 18.432 MHz clock, the only clock
//   iRST_N    : synchronous active-low reset
//   iDATA     : {left[31:16], right[15:0]} two's complement sample
//   iMUTE     : send zeros, sampled when the frame is loaded
//   iATTEN    : arithmetic right-shift amount, sampled when the frame is loaded
//   oDATA_RD  : one-cycle sample request, once per frame
//   oAUD_BCK  : bit clock (registered)
//   oAUD_LRCK : frame clock (registered)
//   oAUD_DATA : serial data, changes on the BCLK falling edge (registered)
//   oAUD_XCK  : DAC master clock, straight copy of iCLK_18_4
module audio_i2s_tx #(
  parameter int I2S_MODE   = 1,
  parameter int FRAME_CLKS = audio_i2s_tx_pkg::FRAME_CLKS,
  parameter int BCK_HALF   = audio_i2s_tx_pkg::BCK_HALF
) (
  input  logic        iCLK_18_4,
  input  logic        iRST_N,
  input  logic [31:0] iDATA,
  input  logic        iMUTE,
  input  logic [3:0]  iATTEN,
  output logic        oDATA_RD,
  output logic        oAUD_BCK,
  output logic        oAUD_LRCK,
  output logic        oAUD_DATA,
  output logic        oAUD_XCK
);

  localparam int FW = audio_i2s_tx_pkg::BITS_PER_FRAME;

  logic          load_stb;
  logic          shift_stb;
  logic          cap_stb;
  logic [31:0]   hold;
  logic [15:0]   left_p;
  logic [15:0]   right_p;
  logic [FW-1:0] frame_word;
  logic [FW-1:0] sr;

  audio_clkgen #(
    .I2S_MODE  (I2S_MODE),
    .FRAME_CLKS(FRAME_CLKS),
    .BCK_HALF  (BCK_HALF)
  ) u_clkgen (
    .clk      (iCLK_18_4),
    .rst_n    (iRST_N),
    .bck      (oAUD_BCK),
    .lrck     (oAUD_LRCK),
    .rd_stb   (oDATA_RD),
    .cap_stb  (cap_stb),
    .load_stb (load_stb),
    .shift_stb(shift_stb)
  );

  // Mute/attenuation are applied on the load cycle, so changes during a
  // frame only take effect on the next one.
  always_comb begin
    left_p  = audio_i2s_tx_pkg::atten_sample(hold[31:16], iATTEN, iMUTE);
    right_p = audio_i2s_tx_pkg::atten_sample(hold[15:0],  iATTEN, iMUTE);
    if (I2S_MODE != 0) begin
      frame_word = {1'b0, left_p, 16'b0, right_p, 15'b0};
    end else begin
      frame_word = {left_p, 16'b0, right_p, 16'b0};
    end
  end

  // The frame MSB goes straight to oAUD_DATA on the load edge, so sr holds
  // only the bits still waiting to be sent; sr[63] is always the next bit.
  always_ff @(posedge iCLK_18_4) begin
    if (!iRST_N) begin
      hold      <= '0;
      sr        <= '0;
      oAUD_DATA <= 1'b0;
    end else begin
      if (cap_stb) begin
        hold <= iDATA;
      end
      if (load_stb) begin
        sr        <= {frame_word[FW-2:0], 1'b0};
        oAUD_DATA <= frame_word[FW-1];
      end else if (shift_stb) begin
        sr        <= {sr[FW-2:0], 1'b0};
        oAUD_DATA <= sr[FW-1];
      end
    end
  end

  assign oAUD_XCK = iCLK_18_4;

endmodule
